// File: rtl/muldiv_if.sv
// Handshake and HI/LO bundle between the register-file read stage and muldiv_unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            mthi;
  logic            mtlo;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle product.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              zero_div_q, zero_div_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Datapath: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    rs_neg    = ~bus.op[0] & bus.rs_val[XLEN-1];
    rt_neg    = ~bus.op[0] & bus.rt_val[XLEN-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    prod_fix  = neg_quo_q ? -acc_q : acc_q;
    quo_fix   = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    zero_div_d = zero_div_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d   = bus.op[1];
          neg_quo_d  = rs_neg ^ rt_neg;
          neg_rem_d  = rs_neg;
          zero_div_d = bus.op[1] & (bus.rt_val == '0);
          cnt_d      = '0;
          if (bus.op[1]) begin
            acc_d   = {{XLEN{1'b0}}, rs_mag};
            opnd_d  = rt_mag;
            state_d = S_RUN;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = {{XLEN{1'b0}}, rs_mag} * {{XLEN{1'b0}}, rt_mag};
            state_d = S_FIX;
`else
            acc_d   = {{XLEN{1'b0}}, rt_mag};
            opnd_d  = rs_mag;
            state_d = S_RUN;
`endif
          end
        end else begin
          // Moves to HI/LO are only honoured when no operation is launching.
          if (bus.mthi) hi_d = bus.rs_val;
          if (bus.mtlo) lo_d = bus.rs_val;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = zero_div_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[2*XLEN-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
        done_d  = 1'b1;
        dbz_d   = zero_div_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_div_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      zero_div_q <= zero_div_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
  localparam int DIV_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
  localparam logic [1:0] RST_OP = OP_DIVU;
`else
  localparam int MUL_LAT = 33;
  localparam logic [1:0] RST_OP = OP_MULT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  int   launch_cyc = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic launch(input string tag, input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = rs;
    bus.rt_val = rt;
    tick();
    launch_cyc = cyc;
    bus.start  = 1'b0;
    check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    check({tag, "_done_low"}, 64'(bus.done), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dbz);
    bit seen = 1'b0;
    bit busy_drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!bus.busy) busy_drop = 1'b1;
      tick();
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(cyc - launch_cyc), 64'(exp_lat));
    check({tag, "_busy_held"}, 64'(busy_drop), 64'd0);
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_dbz", 64'(bus.div_by_zero), 64'd0);

    // MULTU 10 x 20, then confirm done is a single-cycle pulse
    launch("multu", OP_MULTU, 32'd10, 32'd20);
    wait_done("multu", MUL_LAT, 32'h0000_0000, 32'h0000_00C8, 1'b0);
    tick();
    check("multu_done_pulse", 64'(bus.done), 64'd0);

    // Signed multiply and divide sign handling
    launch("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", MUL_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    launch("divu", OP_DIVU, 32'd45, 32'd6);
    wait_done("divu", DIV_LAT, 32'd3, 32'd7, 1'b0);
    launch("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", DIV_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Divide by zero (positive, negative dividend, unsigned) and signed overflow
    launch("div_zero", OP_DIV, 32'd10, 32'd0);
    wait_done("div_zero", DIV_LAT, 32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("div_zero_dbz_pulse", 64'(bus.div_by_zero), 64'd0);
    launch("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done("div_zero_neg", DIV_LAT, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    launch("divu_zero", OP_DIVU, 32'h8000_0001, 32'd0);
    wait_done("divu_zero", DIV_LAT, 32'h8000_0001, 32'hFFFF_FFFF, 1'b1);
    launch("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", DIV_LAT, 32'h0000_0000, 32'h8000_0000, 1'b0);

    // start and mthi while busy are ignored
    launch("ignore", OP_DIVU, 32'd45, 32'd6);
    tick();
    tick();
    tick();
    tick();
    bus.start  = 1'b1;
    bus.op     = OP_MULTU;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd2;
    tick();
    bus.start  = 1'b0;
    bus.mthi   = 1'b1;
    bus.rs_val = 32'h55;
    tick();
    bus.mthi   = 1'b0;
    wait_done("ignore", DIV_LAT, 32'd3, 32'd7, 1'b0);

    // MTLO, then MTHI+MTLO together in IDLE
    tick();
    bus.mtlo   = 1'b1;
    bus.rs_val = 32'h55;
    tick();
    bus.mtlo   = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'h55);
    check("mtlo_hi_kept", 64'(bus.hi), 64'd3);
    check("mtlo_busy", 64'(bus.busy), 64'd0);
    bus.mthi   = 1'b1;
    bus.mtlo   = 1'b1;
    bus.rs_val = 32'hA5A5_0F0F;
    tick();
    bus.mthi   = 1'b0;
    bus.mtlo   = 1'b0;
    check("mtboth_hi", 64'(bus.hi), 64'hA5A5_0F0F);
    check("mtboth_lo", 64'(bus.lo), 64'hA5A5_0F0F);

    // start beats a simultaneous mthi in IDLE
    bus.mthi = 1'b1;
    launch("start_wins", OP_MULTU, 32'd3, 32'd3);
    bus.mthi = 1'b0;
    check("start_wins_hi_kept", 64'(bus.hi), 64'hA5A5_0F0F);
    wait_done("start_wins", MUL_LAT, 32'd0, 32'd9, 1'b0);

    // Back-to-back launches in the done cycle, with extreme operands
    launch("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", MUL_LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    launch("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", MUL_LAT, 32'h4000_0000, 32'h0000_0000, 1'b0);

    // Reset at cycle 10 of an operation aborts it with no done
    launch("abort", RST_OP, 32'hFFFF_FFFD, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    begin
      bit stray_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) stray_done = 1'b1;
        tick();
      end
      check("abort_no_done", 64'(stray_done), 64'd0);
    end
    launch("post_rst", OP_MULTU, 32'd3, 32'd4);
    wait_done("post_rst", MUL_LAT, 32'd0, 32'd12, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS datapath, sitting directly downstream of the register file. It consumes the two register-file read operands (rs, rt) for MULT/MULTU/DIV/DIVU and produces the architectural HI/LO pair. The decode stage reads HI/LO through MFHI/MFLO and sends them back to the register-file write port. The unit holds `busy` while an operation runs so the pipeline stalls any dependent MFHI/MFLO.

## Interface
Parameters:
- `XLEN`, 32: operand and HI/LO width; the iteration count equals `XLEN`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launches an operation; accepted only when `busy`=0.
- `op` in 2: operation select. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val` in XLEN: multiplicand or dividend, taken from register-file data1.
- `rt_val` in XLEN: multiplier or divisor, taken from register-file data2.
- `mthi`, `mtlo` in 1: write `rs_val` into HI or LO (MTHI/MTLO).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO update with a result.
- `div_by_zero` out 1: pulses together with `done` when a DIV/DIVU had `rt_val`=0.
- `hi`, `lo` out XLEN: architectural HI/LO registers.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN: XLEN iterations, counter counts 0..XLEN-1.
  - RUN → FIX after the last iteration.
  - FIX → IDLE unconditionally.
- Operand capture at the accepting edge:
  - Signed ops latch operand magnitudes and record the result signs.
  - Unsigned ops latch the operands as-is.
- Multiply: shift-add, one partial product per cycle, 2·XLEN accumulator.
- Divide: restoring, one quotient bit per cycle.
- FIX:
  - Negates the product, or the quotient/remainder, as required.
  - Writes HI/LO: product high/low, or remainder/quotient.
  - Asserts `done` for that cycle.
- Signed divide sign rules:
  - Quotient is truncated toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero: LO=0xFFFFFFFF, HI=`rs_val`, `div_by_zero`=1, for both signed and unsigned.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- `start` while `busy`=1: ignored, no effect on the running operation.
- `mthi`/`mtlo` in IDLE: HI/LO takes `rs_val` at the next edge. Both asserted together write both registers.
- `mthi`/`mtlo` while `busy`=1: dropped.
- `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the move is dropped.
- HI/LO keep their values until FIX, MTHI/MTLO, or reset.

## Timing
- Reset values:
  - `hi`=0, `lo`=0.
  - `busy`=0, `done`=0, `div_by_zero`=0.
  - State IDLE, counter 0.
- Reset mid-operation aborts immediately: HI/LO are cleared to 0 and no `done` is issued.
- `start` sampled at edge E:
  - `busy`=1 from E through E+XLEN.
  - FIX occupies the cycle after edge E+XLEN.
  - New HI/LO are visible and `done`=1 after edge E+XLEN+1; `busy` is already 0 in that cycle.
  - Total latency is XLEN+1 = 33 cycles.
- Back-to-back: a new `start` is accepted in the `done` cycle.
- `busy` is registered; no combinational path from `start` to `busy`.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `*` product.
  - Path is IDLE → FIX → IDLE: `busy`=1 for exactly one cycle and `done` follows after edge E+1.
  - Divide is unchanged at 33 cycles.
- Not defined: both multiply and divide are iterative, 33 cycles.

## Test plan
- Reset, then MULTU with rs=10, rt=20 → after 33 cycles HI=0x00000000, LO=0x000000C8, `done` pulses once.
- MULT with rs=0xFFFFFFFD (−3), rt=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Repeat with the macro defined → same result, `done` after edge E+1.
- DIVU 45/6 → LO=7, HI=3. DIV 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 10/0 → LO=0xFFFFFFFF, HI=0x0000000A, `div_by_zero`=1 with `done`. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Start DIVU 45/6, then pulse `start` (MULTU 2×2) and `mthi` (rs=0x55) at cycle 5 → both ignored; final LO=7, HI=3. After that, `mtlo` with rs=0x55 in IDLE → LO=0x55 one cycle later.
- Assert `rst` at cycle 10 of a MULT → `busy`=0, HI=LO=0 next cycle, no `done`. A subsequent MULTU 3×4 → LO=12.
